// File: rtl/stopwatch_pkg.sv
// Shared stopwatch defaults and helpers used by the lap capture buffer.
package stopwatch_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_MAX        = 99;

  // Level counters need one extra bit so a completely full buffer is representable.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lap_fifo.sv
// Lap entry storage: circular array with read/write pointers and an occupancy count.
// The caller qualifies push/pop; flush empties the buffer synchronously.
module lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 4,
  localparam int LVL_W     = level_width(DEPTH),
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0]      level,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      count_q, count_d;

  // DEPTH is a power of two, so pointer overflow gives the modulo wrap for free.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + LVL_W'(1);
        2'b01:   count_d = count_q - LVL_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == LVL_W'(DEPTH));
  assign level   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/lap_capture_buffer.sv
// Lap capture buffer: queues stopwatch laps for a show-ahead consumer.
// Define LAP_CAPTURE_DELTA_EN to store split times instead of raw counts.
module lap_capture_buffer
  import stopwatch_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX        = DEFAULT_MAX,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [DATA_WIDTH-1:0]        count_in,
  input  logic                         lap,
  input  logic                         clear,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                         full,
  output logic                         overflow
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX < 1) begin : g_bad_config
    $error("lap_capture_buffer: DEPTH must be a power of two >= 2 and MAX >= 1");
  end

  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] wr_value;

  // Clear wins over everything; a lap into a full buffer survives only if the head leaves.
  assign pop  = rd_ready && !empty && !clear;
  assign push = lap && !clear && (!full || pop);

  always_comb begin
    overflow_d = overflow_q;
    if (clear) begin
      overflow_d = 1'b0;
    end else if (lap && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

`ifdef LAP_CAPTURE_DELTA_EN
  localparam logic [DATA_WIDTH-1:0] WRAP = DATA_WIDTH'(MAX + 1);

  logic [DATA_WIDTH-1:0] prev_q, prev_d;

  // Split is taken modulo the stopwatch period; prev only follows accepted laps.
  always_comb begin
    if (count_in >= prev_q) begin
      wr_value = count_in - prev_q;
    end else begin
      wr_value = count_in + WRAP - prev_q;
    end
    prev_d = prev_q;
    if (clear) begin
      prev_d = '0;
    end else if (push) begin
      prev_d = count_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end
`else
  assign wr_value = count_in;
`endif

  lap_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .flush   (clear),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_value),
    .rd_data (rd_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  assign rd_valid = !empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_lap_capture_buffer.sv
// Directed bench for lap_capture_buffer (DEPTH=4, MAX=99); follows LAP_CAPTURE_DELTA_EN if defined.
module tb_lap_capture_buffer;

  logic        clk;
  logic        resetn;
  logic [15:0] count_in;
  logic        lap;
  logic        clear;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic [2:0]  level;
  logic        full;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  logic [15:0] expq[$];
  logic        expOvf;
`ifdef LAP_CAPTURE_DELTA_EN
  logic [15:0] tbPrev;
`endif

  lap_capture_buffer #(
    .DATA_WIDTH (16),
    .MAX        (99),
    .DEPTH      (4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .count_in (count_in),
    .lap      (lap),
    .clear    (clear),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .level    (level),
    .full     (full),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] splitOf(input logic [15:0] c);
`ifdef LAP_CAPTURE_DELTA_EN
    if (c >= tbPrev) return c - tbPrev;
    return c + 16'd100 - tbPrev;
`else
    return c;
`endif
  endfunction

  task automatic modelReset();
    expq.delete();
    expOvf = 1'b0;
`ifdef LAP_CAPTURE_DELTA_EN
    tbPrev = 16'd0;
`endif
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag);
    logic [15:0] head;
    head = (expq.size() > 0) ? expq[0] : 16'd0;
    checkOutput({tag, ".level"},    32'(level),    32'(expq.size()));
    checkOutput({tag, ".rd_valid"}, 32'(rd_valid), 32'(expq.size() != 0));
    checkOutput({tag, ".rd_data"},  32'(rd_data),  32'(head));
    checkOutput({tag, ".full"},     32'(full),     32'(expq.size() == 4));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(expOvf));
  endtask

  // Drives one cycle of inputs, lets one rising edge pass, and advances the reference model.
  task automatic applyStimulus(input logic doLap, input logic [15:0] cnt,
                               input logic doRead, input logic doClear);
    logic        popped;
    logic        accepted;
    logic [15:0] v;
    count_in = cnt;
    lap      = doLap;
    rd_ready = doRead;
    clear    = doClear;
    if (doClear) begin
      modelReset();
    end else begin
      popped   = doRead && (expq.size() > 0);
      accepted = doLap && ((expq.size() < 4) || popped);
      v        = splitOf(cnt);
      if (popped) void'(expq.pop_front());
      if (accepted) begin
        expq.push_back(v);
`ifdef LAP_CAPTURE_DELTA_EN
        tbPrev = cnt;
`endif
      end else if (doLap) begin
        expOvf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    lap      = 1'b0;
    rd_ready = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    logic [15:0] secondExp;
    resetn   = 1'b0;
    count_in = 16'd0;
    lap      = 1'b0;
    clear    = 1'b0;
    rd_ready = 1'b0;
    modelReset();

    #3;
    checkState("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    $display("[TB] laps at 5,12,30 then drain");
    applyStimulus(1'b1, 16'd5, 1'b0, 1'b0);
    checkOutput("A.first_head", 32'(rd_data), 32'd5);
    applyStimulus(1'b1, 16'd12, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd30, 1'b0, 1'b0);
    checkOutput("A.level3", 32'(level), 32'd3);
    checkState("A.filled");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      checkState($sformatf("A.pop%0d", i));
    end
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    checkOutput("A.empty_pop_level", 32'(level), 32'd0);

    $display("[TB] fill, overflow, then lap+pop while full");
    applyStimulus(1'b1, 16'd10, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd20, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd30, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd40, 1'b0, 1'b0);
    checkOutput("B.full", 32'(full), 32'd1);
    checkState("B.filled");
    applyStimulus(1'b1, 16'd50, 1'b0, 1'b0);
    checkOutput("B.overflow", 32'(overflow), 32'd1);
    checkOutput("B.level_after_drop", 32'(level), 32'd4);
    checkState("B.dropped");
    applyStimulus(1'b1, 16'd60, 1'b1, 1'b0);
    checkOutput("B.level_push_pop", 32'(level), 32'd4);
    checkState("B.push_pop");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      checkState($sformatf("B.drain%0d", i));
    end

    $display("[TB] clear together with lap");
    applyStimulus(1'b1, 16'd70, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd80, 1'b0, 1'b0);
    checkOutput("C.level2", 32'(level), 32'd2);
    applyStimulus(1'b1, 16'd90, 1'b1, 1'b1);
    checkOutput("C.level_cleared", 32'(level), 32'd0);
    checkOutput("C.overflow_cleared", 32'(overflow), 32'd0);
    checkState("C.cleared");
    applyStimulus(1'b1, 16'd5, 1'b0, 1'b0);
    checkOutput("C.first_after_clear", 32'(rd_data), 32'd5);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    checkState("C.drained");

    $display("[TB] async reset mid-stream");
    applyStimulus(1'b1, 16'd11, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd22, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd33, 1'b0, 1'b0);
    checkOutput("D.level3", 32'(level), 32'd3);
    #2;
    resetn = 1'b0;
    #1;
    modelReset();
    checkOutput("D.async_level", 32'(level), 32'd0);
    checkOutput("D.async_rd_valid", 32'(rd_valid), 32'd0);
    checkState("D.in_reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    applyStimulus(1'b1, 16'd7, 1'b0, 1'b0);
    checkOutput("D.first_after_reset", 32'(rd_data), 32'd7);
    checkState("D.after_reset");
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);

    $display("[TB] split values for laps at 40 then 15");
    applyStimulus(1'b1, 16'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'd40, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd15, 1'b0, 1'b0);
`ifdef LAP_CAPTURE_DELTA_EN
    secondExp = 16'd75;
`else
    secondExp = 16'd15;
`endif
    checkOutput("E.first", 32'(rd_data), 32'd40);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    checkOutput("E.second", 32'(rd_data), 32'(secondExp));
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    checkState("E.drained");

    $display("[TB] sustained push/pop across pointer wrap");
    applyStimulus(1'b1, 16'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 16'((i * 7 + 3) % 100), 1'b1, 1'b0);
      checkState($sformatf("F.cycle%0d", i));
    end
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    checkState("F.tail0");
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    checkState("F.tail1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
